// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the text LCD message arbiter.
// The line and message widths describe the 2x16 character display.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    MIN_SHOW,
    SHOW,
    RELEASE
  } arb_state_t;

  localparam int LCD_COLS = 16;
  localparam int LINE_W = 128;
  localparam int MSG_W = 256;
  localparam int CURSOR_W = 7;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  function automatic logic [LINE_W-1:0] blank_line();
    return {LCD_COLS{SPACE_CHAR}};
  endfunction

  // A counter that has to hold max_val needs at least one bit even when max_val is 0
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/lcd_req_prio_enc.sv
// Fixed-priority encoder for the arbiter's request vector.
// The highest set index wins; any_valid flags that at least one bit is set.
module lcd_req_prio_enc #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   grant,
  output logic               any_valid
);

  always_comb begin
    grant = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        grant = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Shares the 2x16 LCD among prioritised requesters, latching the winning message,
// holding it for a minimum time and expiring transient pop-ups.
module lcd_msg_arbiter
  import lcd_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MIN_SHOW_TICKS = 50,
  parameter int HOLD_TICKS = 300
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_transient,
  input  logic [NUM_REQ*MSG_W-1:0]    req_text,
  input  logic [NUM_REQ*CURSOR_W-1:0] req_cursor,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [LINE_W-1:0]           line1_text,
  output logic [LINE_W-1:0]           line2_text,
  output logic [CURSOR_W-1:0]         ddram_address,
  output logic                        refresh,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int MIN_W = cnt_width(MIN_SHOW_TICKS);
  localparam int HOLD_W = cnt_width(HOLD_TICKS);
  localparam logic [MIN_W-1:0] MIN_LOAD = MIN_W'(MIN_SHOW_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  arb_state_t state, state_nxt;
  logic [IDX_W-1:0] grant;
  logic any_valid;
  logic [MIN_W-1:0] min_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic trans;
  logic [MSG_W-1:0] slot_text [NUM_REQ];
  logic [CURSOR_W-1:0] slot_cursor [NUM_REQ];
  logic content_diff;
  logic preempt;
  logic load;
  logic count_tick;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_text[i] = req_text[i*MSG_W +: MSG_W];
    assign slot_cursor[i] = req_cursor[i*CURSOR_W +: CURSOR_W];
  end

  lcd_req_prio_enc #(
    .NUM_REQ(NUM_REQ),
    .IDX_W(IDX_W)
  ) u_prio_enc (
    .req(req_valid),
    .grant(grant),
    .any_valid(any_valid)
  );

  assign content_diff = (slot_text[owner] != {line1_text, line2_text}) ||
                        (slot_cursor[owner] != ddram_address);
  assign preempt = any_valid && (grant > owner);
  // A request that vanished between IDLE and LATCH falls back to IDLE without loading
  assign load = (state == LATCH) && any_valid;
  assign count_tick = tick && ((state == MIN_SHOW) || ((state == SHOW) && (state_nxt == SHOW)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_valid) state_nxt = LATCH;
      LATCH:    state_nxt = any_valid ? MIN_SHOW : IDLE;
      MIN_SHOW: if (min_cnt == '0) state_nxt = SHOW;
      SHOW: begin
        if (preempt) state_nxt = LATCH;
        else if (trans) begin
          if (hold_cnt == '0) state_nxt = RELEASE;
        end
        else if (!req_valid[owner]) state_nxt = RELEASE;
        else if (content_diff) state_nxt = LATCH;
      end
      RELEASE:  state_nxt = any_valid ? LATCH : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    refresh = load;
    busy = (state == MIN_SHOW) || ((state == SHOW) && trans);
    if (load) req_ack[grant] = 1'b1;
  end

  // Displayed content and timers; both counters saturate at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line1_text <= blank_line();
      line2_text <= blank_line();
      ddram_address <= '0;
      owner <= '0;
      trans <= 1'b0;
      min_cnt <= '0;
      hold_cnt <= '0;
    end
    else if (load) begin
      line1_text <= slot_text[grant][MSG_W-1:LINE_W];
      line2_text <= slot_text[grant][LINE_W-1:0];
      ddram_address <= slot_cursor[grant];
      owner <= grant;
      trans <= req_transient[grant];
      min_cnt <= MIN_LOAD;
      hold_cnt <= req_transient[grant] ? HOLD_LOAD : '0;
    end
    else if (count_tick) begin
      if (min_cnt != '0) min_cnt <= min_cnt - MIN_W'(1);
      if (trans && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Self-checking bench for lcd_msg_arbiter: a directed vector table, hand-written
// timing sequences and a random run, all shadowed by a tick-timestamp reference model.
module tb_lcd_msg_arbiter;

  localparam int NUM_REQ = 3;
  localparam int MIN_T = 50;
  localparam int HOLD_T = 300;
  localparam int P_IDLE = 0, P_LATCH = 1, P_MIN = 2, P_SHOW = 3, P_RELEASE = 4;
  localparam logic [127:0] SP = {16{8'h20}};
  localparam logic [127:0] MENU_L1 = "MAIN MENU       ";
  localparam logic [127:0] MENU_L2 = "1:PLAY 2:ADMIN  ";
  localparam logic [127:0] ADMIN_L1 = "ADMIN SCREEN    ";
  localparam logic [127:0] ADMIN_L2 = "USERS: 003      ";
  localparam logic [127:0] ALERT_L1 = "!! ALERT !!     ";
  localparam logic [127:0] ALERT_L2 = "DOOR OPEN       ";

  typedef struct {
    logic       rst;
    logic [2:0] valid;
    logic [2:0] trans;
    int         cycles;
    logic [2:0] ack;
    logic       refresh;
    logic       busy;
    logic [1:0] owner;
    logic [6:0] ddram;
    logic [127:0] line1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic [2:0] valid = '0;
  logic [2:0] trans = '0;
  logic [255:0] text [3];
  logic [6:0] cur [3];
  logic [767:0] req_text;
  logic [20:0] req_cursor;
  logic [2:0] req_ack;
  logic [127:0] line1_text, line2_text;
  logic [6:0] ddram_address;
  logic refresh;
  logic [1:0] owner;
  logic busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int m_phase;
  logic [255:0] m_msg;
  logic [6:0] m_cur;
  int m_owner;
  bit m_trans;
  int m_elapsed;

  vec_t tbl [10];

  always #5 clk = ~clk;

  assign req_text = {text[2], text[1], text[0]};
  assign req_cursor = {cur[2], cur[1], cur[0]};

  lcd_msg_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MIN_SHOW_TICKS(MIN_T),
    .HOLD_TICKS(HOLD_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .req_valid(valid),
    .req_transient(trans),
    .req_text(req_text),
    .req_cursor(req_cursor),
    .req_ack(req_ack),
    .line1_text(line1_text),
    .line2_text(line2_text),
    .ddram_address(ddram_address),
    .refresh(refresh),
    .owner(owner),
    .busy(busy)
  );

  function automatic int top_req();
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (valid[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_msg = {SP, SP};
    m_cur = '0;
    m_owner = 0;
    m_trans = 1'b0;
    m_elapsed = 0;
  endtask

  // Timing is tracked as ticks elapsed since the last latch, compared against the limits
  task automatic model_step();
    int g;
    g = top_req();
    case (m_phase)
      P_IDLE: if (g >= 0) m_phase = P_LATCH;
      P_LATCH: begin
        if (g >= 0) begin
          m_msg = text[g];
          m_cur = cur[g];
          m_owner = g;
          m_trans = trans[g];
          m_elapsed = 0;
          m_phase = P_MIN;
        end
        else m_phase = P_IDLE;
      end
      P_MIN: begin
        if (m_elapsed >= MIN_T) m_phase = P_SHOW;
        if (tick) m_elapsed++;
      end
      P_SHOW: begin
        if (g > m_owner) m_phase = P_LATCH;
        else if (m_trans) begin
          if (m_elapsed >= HOLD_T) m_phase = P_RELEASE;
          else if (tick) m_elapsed++;
        end
        else if (!valid[m_owner]) m_phase = P_RELEASE;
        else if (text[m_owner] != m_msg || cur[m_owner] != m_cur) m_phase = P_LATCH;
      end
      default: m_phase = (g >= 0) ? P_LATCH : P_IDLE;
    endcase
  endtask

  task automatic check_model();
    logic [2:0] e_ack;
    logic e_ref, e_busy;
    int g;
    g = top_req();
    e_ack = '0;
    e_ref = (m_phase == P_LATCH) && (g >= 0);
    if (e_ref) e_ack[g] = 1'b1;
    e_busy = (m_phase == P_MIN) || (m_phase == P_SHOW && m_trans);
    n_vec++;
    if ({req_ack, refresh, busy, owner, ddram_address, line1_text, line2_text} !==
        {e_ack, e_ref, e_busy, 2'(m_owner), m_cur, m_msg}) begin
      n_bad++;
      $display("[TB] FAIL model cyc%0d: got ack=%b ref=%b busy=%b own=%0d dd=%h l1=%h l2=%h, want ack=%b ref=%b busy=%b own=%0d dd=%h l1=%h l2=%h",
               cyc, req_ack, refresh, busy, owner, ddram_address, line1_text, line2_text,
               e_ack, e_ref, e_busy, m_owner, m_cur, m_msg[255:128], m_msg[127:0]);
    end
  endtask

  task automatic half_a();
    @(negedge clk);
    tick = (cyc % 4 == 0);
    cyc++;
    if (rst) model_reset();
    #1 check_model();
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      half_a();
      half_b();
    end
  endtask

  task automatic run_count(input int n, output int refs);
    refs = 0;
    repeat (n) begin
      half_a();
      if (refresh || req_ack != 3'b000) refs++;
      half_b();
    end
  endtask

  task automatic wait_refresh(input int max_cyc, output int got, output int ticks, output logic [2:0] ack_seen);
    got = 0;
    ticks = 0;
    ack_seen = '0;
    for (int i = 0; i < max_cyc && got == 0; i++) begin
      half_a();
      if (refresh) begin
        got = 1;
        ack_seen = req_ack;
      end
      else if (tick) ticks++;
      half_b();
    end
  endtask

  task automatic expect_val(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    valid = v.valid;
    trans = v.trans;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    n_vec++;
    if ({req_ack, refresh, busy, owner, ddram_address, line1_text} !==
        {v.ack, v.refresh, v.busy, v.owner, v.ddram, v.line1}) begin
      n_bad++;
      $display("[TB] FAIL table[%0d]: got ack=%b ref=%b busy=%b own=%0d dd=%h l1=%h, want ack=%b ref=%b busy=%b own=%0d dd=%h l1=%h",
               idx, req_ack, refresh, busy, owner, ddram_address, line1_text,
               v.ack, v.refresh, v.busy, v.owner, v.ddram, v.line1);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int got, ticks, t, refs;
    logic [2:0] ack_seen;

    text[0] = {MENU_L1, MENU_L2};
    text[1] = {ADMIN_L1, ADMIN_L2};
    text[2] = {ALERT_L1, ALERT_L2};
    cur[0] = 7'h40;
    cur[1] = 7'h05;
    cur[2] = 7'h00;
    model_reset();

    tbl[0] = '{1'b1, 3'b000, 3'b000, 3,   3'b000, 1'b0, 1'b0, 2'd0, 7'h00, SP};
    tbl[1] = '{1'b0, 3'b001, 3'b000, 1,   3'b000, 1'b0, 1'b0, 2'd0, 7'h00, SP};
    tbl[2] = '{1'b0, 3'b001, 3'b000, 1,   3'b001, 1'b1, 1'b0, 2'd0, 7'h00, SP};
    tbl[3] = '{1'b0, 3'b001, 3'b000, 1,   3'b000, 1'b0, 1'b1, 2'd0, 7'h40, MENU_L1};
    tbl[4] = '{1'b0, 3'b001, 3'b000, 300, 3'b000, 1'b0, 1'b0, 2'd0, 7'h40, MENU_L1};
    tbl[5] = '{1'b0, 3'b101, 3'b100, 1,   3'b000, 1'b0, 1'b0, 2'd0, 7'h40, MENU_L1};
    tbl[6] = '{1'b0, 3'b101, 3'b100, 1,   3'b100, 1'b1, 1'b0, 2'd0, 7'h40, MENU_L1};
    tbl[7] = '{1'b0, 3'b001, 3'b000, 1,   3'b000, 1'b0, 1'b1, 2'd2, 7'h00, ALERT_L1};
    tbl[8] = '{1'b0, 3'b001, 3'b000, 600, 3'b000, 1'b0, 1'b1, 2'd2, 7'h00, ALERT_L1};
    tbl[9] = '{1'b1, 3'b000, 3'b000, 2,   3'b000, 1'b0, 1'b0, 2'd0, 7'h00, SP};

    for (int k = 0; k < 10; k++) begin
      applyStimulus(tbl[k]);
      for (int c = 0; c < tbl[k].cycles; c++) begin
        half_a();
        if (c == tbl[k].cycles - 1) checkOutput(tbl[k], k);
        half_b();
      end
    end

    // Transient pop-up preempts the menu and expires after exactly HOLD_T ticks
    rst = 1'b0;
    valid = 3'b001;
    trans = 3'b000;
    wait_refresh(10, got, ticks, ack_seen);
    expect_val("menu_latch", 128'(got), 128'(1));
    run_cycles(250);
    valid = 3'b101;
    trans = 3'b100;
    wait_refresh(10, got, ticks, ack_seen);
    expect_val("alert_latch", 128'(got), 128'(1));
    expect_val("alert_ack", 128'(ack_seen), 128'(3'b100));
    expect_val("alert_owner", 128'(owner), 128'(2));
    expect_val("alert_busy", 128'(busy), 128'(1));
    valid = 3'b001;
    trans = 3'b000;
    wait_refresh(2000, got, ticks, ack_seen);
    expect_val("alert_expire", 128'(got), 128'(1));
    expect_val("hold_ticks", 128'(ticks), 128'(HOLD_T));
    expect_val("relatch_ack", 128'(ack_seen), 128'(3'b001));
    expect_val("relatch_owner", 128'(owner), 128'(0));
    run_count(20, refs);
    expect_val("single_refresh", 128'(refs), 128'(0));

    // A higher request 10 ticks into the minimum show waits for tick 50
    rst = 1'b1;
    valid = 3'b000;
    run_cycles(2);
    rst = 1'b0;
    valid = 3'b001;
    wait_refresh(10, got, ticks, ack_seen);
    t = 0;
    refs = 0;
    for (int i = 0; i < 200 && t < 10; i++) begin
      half_a();
      if (tick) t++;
      if (refresh) refs++;
      half_b();
    end
    valid = 3'b011;
    wait_refresh(400, got, ticks, ack_seen);
    expect_val("min_show_ticks", 128'(t + ticks), 128'(MIN_T));
    expect_val("min_show_ack", 128'(ack_seen), 128'(3'b010));
    expect_val("min_show_early", 128'(refs), 128'(0));

    // Content update of a non-transient owner, then a long quiet stretch
    run_cycles(250);
    text[1][231:224] = "Z";
    wait_refresh(10, got, ticks, ack_seen);
    expect_val("update_latch", 128'(got), 128'(1));
    expect_val("update_ack", 128'(ack_seen), 128'(3'b010));
    expect_val("update_char", 128'(line1_text[103:96]), 128'(8'h5A));
    run_count(1000, refs);
    expect_val("update_quiet", 128'(refs), 128'(0));

    // Owner drops with nothing else pending: text stays, a later low request latches
    valid = 3'b000;
    run_count(5, refs);
    expect_val("drop_no_refresh", 128'(refs), 128'(0));
    expect_val("drop_text_kept", line1_text, text[1][255:128]);
    valid = 3'b001;
    wait_refresh(10, got, ticks, ack_seen);
    expect_val("drop_relatch_ack", 128'(ack_seen), 128'(3'b001));
    expect_val("drop_relatch_owner", 128'(owner), 128'(0));

    // Asynchronous reset while owner 2 is in its minimum show
    valid = 3'b100;
    trans = 3'b100;
    wait_refresh(400, got, ticks, ack_seen);
    expect_val("pre_reset_ack", 128'(ack_seen), 128'(3'b100));
    run_cycles(3);
    #2;
    rst = 1'b1;
    valid = 3'b000;
    trans = 3'b000;
    #1;
    expect_val("rst_line1", line1_text, SP);
    expect_val("rst_line2", line2_text, SP);
    expect_val("rst_misc", 128'({ddram_address, owner, busy, refresh, req_ack}), 128'(0));
    model_reset();
    run_cycles(3);
    rst = 1'b0;
    run_count(20, refs);
    expect_val("post_reset_quiet", 128'(refs), 128'(0));
    valid = 3'b001;
    wait_refresh(10, got, ticks, ack_seen);
    expect_val("post_reset_latch", 128'(ack_seen), 128'(3'b001));

    // Random traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      int b, r, by;
      if ($urandom_range(0, 39) == 0) begin
        b = $urandom_range(0, 2);
        valid[b] = ~valid[b];
        trans[b] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 59) == 0) begin
        r = $urandom_range(0, 2);
        by = $urandom_range(0, 31);
        text[r][by*8 +: 8] = 8'($urandom_range(65, 90));
      end
      if ($urandom_range(0, 199) == 0) begin
        r = $urandom_range(0, 2);
        cur[r] = 7'($urandom_range(0, 127));
      end
      half_a();
      half_b();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
